mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the CPU control unit's memory strobes. It samples `rd_mem`/`wr_mem` plus a latched address and write data, inserts a programmable number of wait states, and then performs the access on an internal single-port RAM. It completes each access with a one-cycle `mem_ready` pulse, with `data_valid` also pulsed for reads. It sits between the datapath address/data buses and storage, and gives the controller a defined completion handshake in place of an implied single-cycle memory.

## Interface
- `ADDR_W`, default 8: address width; RAM depth is 2**ADDR_W words.
- `DATA_W`, default 8: word width.
- `WAIT_CYCLES`, default 1: wait states inserted before the access; legal range 0..15.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `rd_mem` in 1: read request.
- `wr_mem` in 1: write request.
- `adr` in ADDR_W: access address.
- `data_in` in DATA_W: write data from the data bus.
- `data_out` out DATA_W: read data register.
- `data_valid` out 1: one-cycle pulse; `data_out` holds a fresh read.
- `mem_ready` out 1: one-cycle pulse; the access (or rejected request) is complete.
- `busy` out 1: high in WAIT and RESPOND.
- `err` out 1: one-cycle pulse with `mem_ready` when `rd_mem` and `wr_mem` were both high at acceptance.

## Operation
- FSM states:
  - IDLE: requests are sampled only in this state. On a `rd_mem` or `wr_mem` edge, capture `adr`, `data_in` and the request kind. Go to WAIT with `cnt`=WAIT_CYCLES-1 if WAIT_CYCLES>0. Otherwise perform the access on this edge and go to RESPOND.
  - WAIT: decrement `cnt` each edge. On the edge where `cnt`==0, perform the access and go to RESPOND.
  - RESPOND: `mem_ready`=1. `data_valid`=1 if the access was a read. `err`=1 if the request was illegal. The next edge always goes to IDLE.
- The access uses only captured values. Changes on `adr`/`data_in`/strobes after acceptance have no effect.
- Read: `data_out` is loaded with RAM[captured adr] on the access edge. It holds that value until the next read access or reset.
- Write: RAM[captured adr] is written with the captured data on the access edge. `data_out` is unchanged.
- Illegal request (both strobes high at acceptance): no RAM access and no `data_out` change. It still goes through WAIT/RESPOND with `err`=1.
- Requester rule: drop the strobes during the RESPOND cycle. A strobe still high at the following IDLE edge is a new access.
- Reset:
  - Returns to IDLE, clears `cnt` and the capture registers, and sets all outputs to 0 (`data_out`=0, `data_valid`=0, `mem_ready`=0, `busy`=0, `err`=0).
  - RAM contents are not cleared by reset and are undefined after power-up.
  - Reset during WAIT aborts the access: no RAM write, no `mem_ready`.
  - Reset asserted on an access edge takes priority over the access.
- The address range is full, so there is no out-of-range case. `cnt` is a 4-bit down-counter with no wrap: it is only decremented while nonzero, or consumed at zero.

## Timing
- Request visible before edge E0 (IDLE) → access on edge E(WAIT_CYCLES) → `mem_ready` high for the cycle following that edge.
- Latency from E0 to `mem_ready` is WAIT_CYCLES+1 cycles.
- Minimum access period is WAIT_CYCLES+2 cycles (accept, waits, RESPOND), with IDLE re-sampling on the edge after RESPOND.
- `busy` rises in the cycle after E0 and falls in the cycle after RESPOND.
- Read-after-write to the same address returns the new data, because the write commits before the next request can be accepted.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset values: assert `reset` for 2 cycles mid-WAIT of a write to 0x10 → all outputs 0, back in IDLE. A later read of 0x10 returns the pre-write contents, with no `mem_ready` for the aborted write.
- Write then read with WAIT_CYCLES=1: write 0xA5 to 0x3C → `mem_ready` 2 cycles after acceptance, `data_valid`=0. Read 0x3C → `data_out`=0xA5 with `data_valid`=`mem_ready`=1 for exactly one cycle.
- WAIT_CYCLES=0 and WAIT_CYCLES=3 builds: read latency measured as 1 and 4 cycles respectively; `busy` width 1 and 4 cycles.
- Captured-operand check: after acceptance of a write of 0x11 to 0x05, change `adr` to 0x06 and `data_in` to 0x22 during WAIT → RAM[0x05]=0x11, RAM[0x06] unchanged.
- Illegal request: `rd_mem`=`wr_mem`=1 at 0x20 holding 0x7E → `mem_ready`=`err`=1, `data_valid`=0, `data_out` unchanged, RAM[0x20] still 0x7E.
- Strobes held through RESPOND: keep `rd_mem` high continuously → a second, separate read is accepted at the next IDLE edge, one access every WAIT_CYCLES+2 cycles.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the control unit's memory strobes.
// A request is accepted only in IDLE. The responder captures the address,
// the write data and the request kind, then waits WAIT_CYCLES cycles. It then
// performs the access on an internal single-port RAM and signals completion
// with a one-cycle mem_ready pulse. data_valid is pulsed with mem_ready for
// reads, and err is pulsed with it for an illegal request (both strobes high).
//
// Parameters:
//   ADDR_W      address width, RAM depth is 2**ADDR_W words
//   DATA_W      word width
//   WAIT_CYCLES wait states before the access (0..15)
// Ports:
//   clk        single clock, rising edge
//   reset      synchronous, active-high
//   rd_mem     read request strobe
//   wr_mem     write request strobe
//   adr        access address
//   data_in    write data
//   data_out   read data register (holds the last read)
//   data_valid one-cycle pulse, data_out holds a fresh read
//   mem_ready  one-cycle pulse, access or rejected request complete
//   busy       high while in WAIT or RESPOND
//   err        one-cycle pulse with mem_ready for an illegal request
module mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_mem,
    input  logic              wr_mem,
    input  logic [ADDR_W-1:0] adr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              mem_ready,
    output logic              busy,
    output logic              err
);

    localparam int         DEPTH    = 1 << ADDR_W;
    localparam bit         NO_WAIT  = (WAIT_CYCLES == 0);
    // The counter is loaded with WAIT_CYCLES-1 because the accept edge
    // already counts as the first of the waits.
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RESPOND = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic [3:0]          cnt_r;
    logic [3:0]          cnt_next_s;
    logic [ADDR_W-1:0]   cap_adr_r;
    logic [DATA_W-1:0]   cap_data_r;
    logic                cap_rd_r;
    logic                cap_wr_r;

    logic                accept_s;
    logic                access_s;
    logic [ADDR_W-1:0]   acc_adr_s;
    logic [DATA_W-1:0]   acc_data_s;
    logic                acc_rd_s;
    logic                acc_wr_s;
    logic                do_read_s;
    logic                do_write_s;
    logic                illegal_s;

    logic [DATA_W-1:0]   data_out_r;
    logic                data_valid_r;
    logic                mem_ready_r;
    logic                busy_r;
    logic                err_r;

    logic [DATA_W-1:0]   mem_r [0:DEPTH-1];

    // Next-state, counter and access-strobe decode.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        accept_s     = 1'b0;
        access_s     = 1'b0;
        acc_adr_s    = cap_adr_r;
        acc_data_s   = cap_data_r;
        acc_rd_s     = cap_rd_r;
        acc_wr_s     = cap_wr_r;
        case (state_r)
            ST_IDLE: begin
                if (rd_mem || wr_mem) begin
                    accept_s = 1'b1;
                    if (NO_WAIT) begin
                        // Zero wait states: the access happens on the accept
                        // edge itself, so it uses the live inputs that are
                        // being captured on this same edge.
                        access_s     = 1'b1;
                        acc_adr_s    = adr;
                        acc_data_s   = data_in;
                        acc_rd_s     = rd_mem;
                        acc_wr_s     = wr_mem;
                        cnt_next_s   = 4'd0;
                        state_next_s = ST_RESPOND;
                    end else begin
                        cnt_next_s   = CNT_INIT;
                        state_next_s = ST_WAIT;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    access_s     = 1'b1;
                    state_next_s = ST_RESPOND;
                end else begin
                    cnt_next_s   = cnt_r - 4'd1;
                    state_next_s = ST_WAIT;
                end
            end
            ST_RESPOND: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = 4'd0;
            end
        endcase
    end

    // Classify the access; an illegal request touches neither RAM nor data_out.
    always_comb begin
        illegal_s  = acc_rd_s & acc_wr_s;
        do_read_s  = access_s & acc_rd_s & ~acc_wr_s;
        do_write_s = access_s & acc_wr_s & ~acc_rd_s;
    end

    // State, counter, capture and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 4'd0;
            cap_adr_r    <= '0;
            cap_data_r   <= '0;
            cap_rd_r     <= 1'b0;
            cap_wr_r     <= 1'b0;
            data_out_r   <= '0;
            data_valid_r <= 1'b0;
            mem_ready_r  <= 1'b0;
            busy_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            cnt_r        <= cnt_next_s;
            if (accept_s) begin
                cap_adr_r  <= adr;
                cap_data_r <= data_in;
                cap_rd_r   <= rd_mem;
                cap_wr_r   <= wr_mem;
            end
            if (do_read_s) begin
                data_out_r <= mem_r[acc_adr_s];
            end
            // The access edge is the edge that enters RESPOND, so the
            // completion flags registered here are visible exactly in RESPOND.
            mem_ready_r  <= access_s;
            data_valid_r <= do_read_s;
            err_r        <= access_s & illegal_s;
            busy_r       <= (state_next_s != ST_IDLE);
        end
    end

    // RAM write port; contents are not reset, and reset blocks a pending write.
    always_ff @(posedge clk) begin
        if (do_write_s && !reset) begin
            mem_r[acc_adr_s] <= acc_data_s;
        end
    end

    assign data_out   = data_out_r;
    assign data_valid = data_valid_r;
    assign mem_ready  = mem_ready_r;
    assign busy       = busy_r;
    assign err        = err_r;

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder. Three instances (WAIT_CYCLES = 0, 1, 3) share
// one stimulus. Requests are spaced so that every instance handles every
// request. Each instance has its own reference RAM image, because a reset
// can abort a write in one instance but not in another.
module tb_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       rd_mem;
    logic       wr_mem;
    logic [7:0] adr;
    logic [7:0] data_in;

    logic [7:0] dout [3];
    logic       dv   [3];
    logic       rdy  [3];
    logic       bsy  [3];
    logic       er   [3];

    mem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(reset), .rd_mem(rd_mem), .wr_mem(wr_mem),
        .adr(adr), .data_in(data_in), .data_out(dout[0]), .data_valid(dv[0]),
        .mem_ready(rdy[0]), .busy(bsy[0]), .err(er[0]));

    mem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(1)) u_dut1 (
        .clk(clk), .reset(reset), .rd_mem(rd_mem), .wr_mem(wr_mem),
        .adr(adr), .data_in(data_in), .data_out(dout[1]), .data_valid(dv[1]),
        .mem_ready(rdy[1]), .busy(bsy[1]), .err(er[1]));

    mem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .reset(reset), .rd_mem(rd_mem), .wr_mem(wr_mem),
        .adr(adr), .data_in(data_in), .data_out(dout[2]), .data_valid(dv[2]),
        .mem_ready(rdy[2]), .busy(bsy[2]), .err(er[2]));

    int checks = 0;
    int errors = 0;

    // Reference model: the RAM image and the last read value of each instance.
    logic [7:0] mem_m  [3][256];
    logic [7:0] dout_m [3];

    typedef struct {
        bit         r;
        bit         w;
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] alt_a;
        logic [7:0] alt_d;
        bit         exp_dv;
        bit         exp_err;
        bit         chk_dout;
        logic [7:0] exp_dout;
    } vec_t;

    vec_t tbl [10];

    function automatic int wc_of(input int i);
        return (i == 0) ? 0 : ((i == 1) ? 1 : 3);
    endfunction

    task automatic check(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (WAIT_CYCLES=%0d): got %0h expected %0h", name, wc_of(idx), act, exp);
        end
    endtask

    task automatic check_all_zero(input string name);
        for (int i = 0; i < 3; i++) begin
            check({name, "_data_out"},   i, int'(dout[i]), 0);
            check({name, "_data_valid"}, i, int'(dv[i]),   0);
            check({name, "_mem_ready"},  i, int'(rdy[i]),  0);
            check({name, "_busy"},       i, int'(bsy[i]),  0);
            check({name, "_err"},        i, int'(er[i]),   0);
        end
    endtask

    // One request presented for a single edge, then 8 observed cycles.
    // alt_a/alt_d are driven on the buses after acceptance.
    task automatic run_txn(input bit r, input bit w, input logic [7:0] a, input logic [7:0] d,
                           input logic [7:0] alt_a, input logic [7:0] alt_d,
                           output logic [7:0] m_dout, output bit m_dv, output bit m_err);
        int         rdy_at   [3];
        int         rdy_n    [3];
        int         bsy_n    [3];
        int         bsy_frst [3];
        int         stray    [3];
        logic       dv_at    [3];
        logic       err_at   [3];
        logic [7:0] dout_at  [3];
        bit         acc;
        for (int i = 0; i < 3; i++) begin
            rdy_at[i] = -1; rdy_n[i] = 0; bsy_n[i] = 0; bsy_frst[i] = -1; stray[i] = 0;
            dv_at[i] = 1'b0; err_at[i] = 1'b0; dout_at[i] = 8'h00;
        end
        @(negedge clk);
        rd_mem = r; wr_mem = w; adr = a; data_in = d;
        @(negedge clk);
        rd_mem = 1'b0; wr_mem = 1'b0; adr = alt_a; data_in = alt_d;
        for (int k = 1; k <= 8; k++) begin
            for (int i = 0; i < 3; i++) begin
                if (rdy[i]) begin
                    rdy_n[i]++;
                    if (rdy_at[i] < 0) begin
                        rdy_at[i] = k; dv_at[i] = dv[i]; err_at[i] = er[i]; dout_at[i] = dout[i];
                    end
                end else if (dv[i] || er[i]) begin
                    stray[i]++;
                end else begin
                    stray[i] = stray[i];
                end
                if (bsy[i]) begin
                    bsy_n[i]++;
                    if (bsy_frst[i] < 0) bsy_frst[i] = k;
                end
            end
            @(negedge clk);
        end
        acc = r | w;
        for (int i = 0; i < 3; i++) begin
            check("ready_count", i, rdy_n[i], acc ? 1 : 0);
            check("stray_pulse", i, stray[i], 0);
            if (acc) begin
                check("latency",    i, rdy_at[i], wc_of(i) + 1);
                check("busy_width", i, bsy_n[i],  wc_of(i) + 1);
                check("busy_start", i, bsy_frst[i], 1);
                check("data_valid", i, int'(dv_at[i]),  (r && !w) ? 1 : 0);
                check("err",        i, int'(err_at[i]), (r && w) ? 1 : 0);
                if (r && !w) dout_m[i] = mem_m[i][a];
                check("data_out",   i, int'(dout_at[i]), int'(dout_m[i]));
                if (w && !r) mem_m[i][a] = d;
            end else begin
                check("idle_busy",  i, bsy_n[i], 0);
            end
        end
        m_dout = dout_at[1];
        m_dv   = dv_at[1];
        m_err  = err_at[1];
    endtask

    initial begin
        logic [7:0] md;
        bit         mdv;
        bit         merr;
        bit         r;
        bit         w;

        reset = 1'b1; rd_mem = 1'b0; wr_mem = 1'b0; adr = 8'h00; data_in = 8'h00;
        for (int i = 0; i < 3; i++) dout_m[i] = 8'h00;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        // Give every RAM word a known value so reads are deterministic.
        for (int a = 0; a < 256; a++) begin
            run_txn(1'b0, 1'b1, 8'(a), 8'(a) ^ 8'h5A, 8'($urandom), 8'($urandom), md, mdv, merr);
        end

        tbl[0] = '{1'b0, 1'b1, 8'h3C, 8'hA5, 8'h3C, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[1] = '{1'b1, 1'b0, 8'h3C, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA5};
        tbl[2] = '{1'b0, 1'b1, 8'h05, 8'h11, 8'h06, 8'h22, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[3] = '{1'b1, 1'b0, 8'h05, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 8'h11};
        tbl[4] = '{1'b1, 1'b0, 8'h06, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 8'h5C};
        tbl[5] = '{1'b0, 1'b1, 8'h20, 8'h7E, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[6] = '{1'b1, 1'b1, 8'h20, 8'h99, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 8'h5C};
        tbl[7] = '{1'b1, 1'b0, 8'h20, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 8'h7E};
        tbl[8] = '{1'b0, 1'b1, 8'h10, 8'h33, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[9] = '{1'b1, 1'b0, 8'h10, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 8'h33};
        for (int t = 0; t < 10; t++) begin
            run_txn(tbl[t].r, tbl[t].w, tbl[t].a, tbl[t].d, tbl[t].alt_a, tbl[t].alt_d, md, mdv, merr);
            check($sformatf("tbl%0d_data_valid", t), 1, int'(mdv),  int'(tbl[t].exp_dv));
            check($sformatf("tbl%0d_err", t),        1, int'(merr), int'(tbl[t].exp_err));
            if (tbl[t].chk_dout) check($sformatf("tbl%0d_data_out", t), 1, int'(md), int'(tbl[t].exp_dout));
        end

        // Reset mid-WAIT of a write to 0x10: aborted where the access had not yet happened.
        @(negedge clk);
        wr_mem = 1'b1; adr = 8'h10; data_in = 8'hC3;
        @(negedge clk);
        wr_mem = 1'b0; reset = 1'b1;
        @(negedge clk);
        check_all_zero("abort_k2");
        @(negedge clk);
        check_all_zero("abort_k3");
        reset = 1'b0;
        for (int i = 0; i < 3; i++) dout_m[i] = 8'h00;
        mem_m[0][8'h10] = 8'hC3;   // zero wait states: written on the accept edge
        run_txn(1'b1, 1'b0, 8'h10, 8'h00, 8'h00, 8'h00, md, mdv, merr);
        check("abort_prewrite_read", 1, int'(md), 32'h33);

        // Read strobe held high for edges 0..11: repeated accesses, period WAIT_CYCLES+2.
        @(negedge clk);
        rd_mem = 1'b1; adr = 8'h3C;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 12) rd_mem = 1'b0;
            for (int i = 0; i < 3; i++) begin
                int e;
                bit exp;
                e   = k - (wc_of(i) + 1);
                exp = (e >= 0) && (e <= 11) && ((e % (wc_of(i) + 2)) == 0);
                check($sformatf("held_ready_k%0d", k), i, int'(rdy[i]), int'(exp));
                check($sformatf("held_valid_k%0d", k), i, int'(dv[i]),  int'(exp));
                if (exp) check($sformatf("held_data_k%0d", k), i, int'(dout[i]), int'(mem_m[i][8'h3C]));
            end
        end
        for (int i = 0; i < 3; i++) dout_m[i] = mem_m[i][8'h3C];

        // Random traffic, including idle slots and illegal requests.
        for (int n = 0; n < 150; n++) begin
            r = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            run_txn(r, w, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), md, mdv, merr);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
